// File: rtl/id_ex_stage_reg_if.sv
// ID/EX stage bundle: decode-side inputs, EX-side registered outputs and the stall request.
interface id_ex_stage_reg_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  Flush;
    logic                  ID_Valid;
    logic [8:0]            ID_Ctrl;
    logic                  ID_UsesRt;
    logic [DATA_W-1:0]     ID_RsData;
    logic [DATA_W-1:0]     ID_RtData;
    logic [DATA_W-1:0]     ID_Imm;
    logic [DATA_W-1:0]     ID_PC4;
    logic [REG_ADDR_W-1:0] ID_Rs;
    logic [REG_ADDR_W-1:0] ID_Rt;
    logic [REG_ADDR_W-1:0] ID_Rd;

    logic                  EX_Valid;
    logic [8:0]            EX_Ctrl;
    logic [DATA_W-1:0]     EX_RsData;
    logic [DATA_W-1:0]     EX_RtData;
    logic [DATA_W-1:0]     EX_Imm;
    logic [DATA_W-1:0]     EX_PC4;
    logic [REG_ADDR_W-1:0] EX_Rs;
    logic [REG_ADDR_W-1:0] EX_Rt;
    logic [REG_ADDR_W-1:0] EX_Rd;
    logic [REG_ADDR_W-1:0] EX_WriteReg;
    logic                  Stall;

    modport master (
        output Flush, ID_Valid, ID_Ctrl, ID_UsesRt, ID_RsData, ID_RtData,
               ID_Imm, ID_PC4, ID_Rs, ID_Rt, ID_Rd,
        input  EX_Valid, EX_Ctrl, EX_RsData, EX_RtData, EX_Imm, EX_PC4,
               EX_Rs, EX_Rt, EX_Rd, EX_WriteReg, Stall
    );

    modport slave (
        input  Flush, ID_Valid, ID_Ctrl, ID_UsesRt, ID_RsData, ID_RtData,
               ID_Imm, ID_PC4, ID_Rs, ID_Rt, ID_Rd,
        output EX_Valid, EX_Ctrl, EX_RsData, EX_RtData, EX_Imm, EX_PC4,
               EX_Rs, EX_Rt, EX_Rd, EX_WriteReg, Stall
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional STALL_CNT_EN adds a saturating 32-bit Stall_Count output.
module id_ex_stage_reg #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                Clk,
    input  logic                Rst_n,
    id_ex_stage_reg_if.slave    bus
`ifdef STALL_CNT_EN
    ,
    output logic [31:0]         Stall_Count
`endif
);

    logic                  valid_q,     valid_d;
    logic [8:0]            ctrl_q,      ctrl_d;
    logic [DATA_W-1:0]     rs_data_q,   rs_data_d;
    logic [DATA_W-1:0]     rt_data_q,   rt_data_d;
    logic [DATA_W-1:0]     imm_q,       imm_d;
    logic [DATA_W-1:0]     pc4_q,       pc4_d;
    logic [REG_ADDR_W-1:0] rs_q,        rs_d;
    logic [REG_ADDR_W-1:0] rt_q,        rt_d;
    logic [REG_ADDR_W-1:0] rd_q,        rd_d;
    logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;

    logic hazard;
    logic bubble;
    logic stall;

    always_comb begin
        // EX holds a valid load whose non-$zero target is read by the ID instruction
        hazard = valid_q & ctrl_q[4] & (rt_q != '0) & bus.ID_Valid &
                 ((bus.ID_Rs == rt_q) | (bus.ID_UsesRt & (bus.ID_Rt == rt_q)));
        stall  = hazard & ~bus.Flush;
        bubble = bus.Flush | hazard;

        valid_d     = bus.ID_Valid;
        ctrl_d      = bus.ID_Valid ? bus.ID_Ctrl : '0;
        rs_data_d   = bus.ID_RsData;
        rt_data_d   = bus.ID_RtData;
        imm_d       = bus.ID_Imm;
        pc4_d       = bus.ID_PC4;
        rs_d        = bus.ID_Rs;
        rt_d        = bus.ID_Rt;
        rd_d        = bus.ID_Rd;
        write_reg_d = bus.ID_Ctrl[8] ? bus.ID_Rd : bus.ID_Rt;

        if (bubble) begin
            valid_d     = 1'b0;
            ctrl_d      = '0;
            rs_data_d   = '0;
            rt_data_d   = '0;
            imm_d       = '0;
            pc4_d       = '0;
            rs_d        = '0;
            rt_d        = '0;
            rd_d        = '0;
            write_reg_d = '0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            valid_q     <= 1'b0;
            ctrl_q      <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            pc4_q       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            write_reg_q <= '0;
        end else begin
            valid_q     <= valid_d;
            ctrl_q      <= ctrl_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            pc4_q       <= pc4_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            write_reg_q <= write_reg_d;
        end
    end

    assign bus.EX_Valid    = valid_q;
    assign bus.EX_Ctrl     = ctrl_q;
    assign bus.EX_RsData   = rs_data_q;
    assign bus.EX_RtData   = rt_data_q;
    assign bus.EX_Imm      = imm_q;
    assign bus.EX_PC4      = pc4_q;
    assign bus.EX_Rs       = rs_q;
    assign bus.EX_Rt       = rt_q;
    assign bus.EX_Rd       = rd_q;
    assign bus.EX_WriteReg = write_reg_q;
    assign bus.Stall       = stall;

`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign Stall_Count = stall_cnt_q;
`endif

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register for the 5-stage 32-bit MIPS core, with built-in load-use hazard detection.
- Captures decoded control and operand data from the decode stage each cycle.
- Drives the EX-stage 2:1 operand and destination muxes: EX_Ctrl[7] (ALUSrc) is the select of the ALU-B mux, EX_Ctrl[8] (RegDst) selects Rd/Rt.
- Generates the one-cycle Stall that freezes the PC and IF/ID, and inserts bubbles on stall or flush.

Parameters:
- DATA_W, 32, width of operand, immediate and PC+4 fields.
- REG_ADDR_W, 5, register-file address width.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- Flush  input  1  wrong-path squash (taken branch/jump); ID instruction is discarded.
- ID_Valid  input  1  decode stage holds a real instruction.
- ID_Ctrl  input  9  control bundle: [8] RegDst, [7] ALUSrc, [6] MemtoReg, [5] RegWrite, [4] MemRead, [3] MemWrite, [2] Branch, [1:0] ALUOp.
- ID_UsesRt  input  1  instruction reads Rt as a source (R-type, store, branch).
- ID_RsData, ID_RtData  input  DATA_W  register-file read data.
- ID_Imm  input  DATA_W  sign-extended immediate.
- ID_PC4  input  DATA_W  PC+4 of the instruction.
- ID_Rs, ID_Rt, ID_Rd  input  REG_ADDR_W  register specifiers.
- EX_Valid  output  1  registered valid.
- EX_Ctrl  output  9  registered control bundle.
- EX_RsData, EX_RtData, EX_Imm, EX_PC4  output  DATA_W  registered data.
- EX_Rs, EX_Rt, EX_Rd  output  REG_ADDR_W  registered specifiers.
- EX_WriteReg  output  REG_ADDR_W  registered destination: ID_Ctrl[8] ? ID_Rd : ID_Rt, captured at load time.
- Stall  output  1  hold PC and IF/ID this cycle.

Behaviour:
- Reset (Rst_n=0, asynchronous): every registered output goes to 0 immediately, including EX_Valid, EX_Ctrl and all data/specifier fields. Stall then evaluates to 0. Reset mid-stall or mid-flush discards all state.
- Hazard (combinational from current state and ID inputs): EX_Valid & EX_Ctrl[4] & (EX_Rt != 0) & ID_Valid & ((ID_Rs == EX_Rt) | (ID_UsesRt & (ID_Rt == EX_Rt))).
- Stall = Hazard & ~Flush. Flush always wins, so IF/ID is free to load the branch target.
- Register update on each rising Clk edge, priority Flush > Hazard > Load:
  - Flush or Hazard (bubble): EX_Valid=0, EX_Ctrl=0, all data and specifier fields = 0.
  - Load: every EX_* field takes its ID_* value, EX_Valid=ID_Valid, EX_WriteReg resolved as above. If ID_Valid=0, EX_Ctrl is forced to 0 and data is still captured.
- Latency: one cycle ID to EX. A load-use pair costs exactly one bubble. The cycle after the bubble, EX holds a non-load (MemRead=0), Stall drops, and the held consumer enters EX on the following edge.
- Back-to-back loads where the second depends on the first: one bubble only. Second load then sits in EX and is checked against the next ID instruction normally.
- $zero: EX_Rt == 0 never raises Hazard.
- No internal state beyond the pipeline register (plus the optional counter). No X on any output after reset.

Optional Feature:
- Macro: STALL_CNT_EN.
- Defined: adds output Stall_Count (32-bit). Async reset to 0. Increments by 1 on every Clk edge where Stall=1. Saturates at 32'hFFFFFFFF with no wrap.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: Rst_n=0 asserted mid-cycle with all ID inputs at 1s -> all EX_* outputs go 0 immediately without a clock edge; Stall=0.
- Pass-through: ID_Valid=1, ID_Ctrl=9'h1A2, ID_RsData=32'h1234_5678, ID_Rt=5'd9, ID_Rd=5'd3 (RegDst=1) -> after 1 edge, EX_Ctrl=9'h1A2, EX_RsData=32'h1234_5678, EX_WriteReg=3.
- Load-use: EX holds lw to $8 (EX_Ctrl[4]=1, EX_Rt=8); ID add with ID_Rs=8 -> Stall=1 for exactly 1 cycle; next EX_Valid=0, EX_Ctrl=0; add enters EX on the following edge.
- Rt-only dependency: ID_Rt=8 with ID_UsesRt=0 -> Stall=0. Same case with EX_Rt=0 -> Stall=0.
- Flush with hazard: Hazard condition true and Flush=1 -> Stall=0; EX bubble on next edge.
- Counter (STALL_CNT_EN): 3 load-use pairs -> Stall_Count=3; preload 32'hFFFFFFFF and stall once -> value stays 32'hFFFFFFFF.
